// File: rtl/data_memory_pkg.sv
// Shared types and default sizes for the byte-enabled data memory and its
// zero-fill sequencer.
package data_memory_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 6;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/data_memory_v2_clear_fsm.sv
// Zero-fill sequencer: after reset it sweeps every word address once,
// then parks in READY. The state is exported so the top and checkers see it.
module mem_clear_fsm
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] sweep_addr,
  output logic                  sweep_we,
  output logic                  ready,
  output mem_state_e            state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  mem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter wraps to zero exactly on the edge that clears the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    sweep_addr = cnt_q;
    sweep_we   = (state_q == CLEAR);
    ready      = (state_q == READY);
    state      = state_q;
  end

endmodule

// File: rtl/data_memory_v2.sv
// Single-port word memory with per-byte write enables, write-first reads,
// a registered read port and a zero-fill sweep after every reset.
module data_memory_v2
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [DATA_WIDTH/8-1:0]   be,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic [ADDR_WIDTH-1:0]     mem_address,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      rd_valid,
  output logic                      ready,
  output logic                      err
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  sweep_we;
  mem_state_e            state;

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  accept_wr, accept_rd;

  mem_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_fsm (
    .clk        (clk),
    .rst        (rst),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we),
    .ready      (ready),
    .state      (state)
  );

  // Requests are only honoured once the sweep has finished.
  always_comb begin
    accept_wr = wr_en && (state == READY);
    accept_rd = rd_en && (state == READY);
  end

  always_comb begin
    merged_word = mem_q[mem_address];
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) merged_word[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  // Write-first: a read colliding with a write returns the merged word.
  always_comb begin
    data_out_d = data_out_q;
    if (accept_rd) data_out_d = accept_wr ? merged_word : mem_q[mem_address];
    rd_valid_d = accept_rd;
    err_d      = (wr_en || rd_en) && (state == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_addr] <= '0;
    end else if (accept_wr) begin
      mem_q[mem_address] <= merged_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_memory_v2.sv
// Directed self-checking bench for data_memory_v2: reset sweep, byte-enabled
// writes, write-first collisions, back-to-back reads and reset aborts.
module tb_data_memory_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  be;
  logic [15:0] data_in;
  logic [5:0]  mem_address;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        ready;
  logic        err;

  int total = 0;
  int bad   = 0;

  data_memory_v2 dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .be          (be),
    .data_in     (data_in),
    .mem_address (mem_address),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .ready       (ready),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    be = 2'b00;
    data_in = 16'h0000;
    mem_address = 6'd0;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [15:0] d, input logic [1:0] b);
    wr_en = 1'b1;
    mem_address = a;
    data_in = d;
    be = b;
    cyc();
    idle();
  endtask

  task automatic do_read(input logic [5:0] a);
    rd_en = 1'b1;
    mem_address = a;
    cyc();
    idle();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      cyc();
      n++;
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    repeat (3) cyc();
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL reset_data_out: got %h want 0000", data_out); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      cyc();
      total++;
      if (ready !== (k == 64)) begin
        bad++;
        $display("FAIL sweep_ready edge %0d: got %b want %b", k, ready, (k == 64));
      end
    end
  endtask

  task automatic test_read_zero();
    do_read(6'd0);
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL read0_valid: got %b want 1", rd_valid); end
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL read0_data: got %h want 0000", data_out); end
    cyc();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL read0_pulse: got %b want 0", rd_valid); end
  endtask

  task automatic test_write_read();
    do_write(6'd0, 16'h0C60, 2'b11);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", err); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL wr_no_valid: got %b want 0", rd_valid); end
    do_read(6'd0);
    total++; if (data_out !== 16'h0C60) begin bad++; $display("FAIL wr_read: got %h want 0c60", data_out); end
    cyc();
    total++; if (data_out !== 16'h0C60) begin bad++; $display("FAIL data_hold: got %h want 0c60", data_out); end
  endtask

  task automatic test_byte_enable();
    do_write(6'd1, 16'hFFF0, 2'b11);
    do_write(6'd1, 16'h11E4, 2'b01);
    do_read(6'd1);
    total++; if (data_out !== 16'hFFE4) begin bad++; $display("FAIL be_low: got %h want ffe4", data_out); end
    do_write(6'd1, 16'h5555, 2'b00);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL be_zero_err: got %b want 0", err); end
    do_read(6'd1);
    total++; if (data_out !== 16'hFFE4) begin bad++; $display("FAIL be_zero_data: got %h want ffe4", data_out); end
    do_write(6'd1, 16'h12AB, 2'b10);
    do_read(6'd1);
    total++; if (data_out !== 16'h12E4) begin bad++; $display("FAIL be_high: got %h want 12e4", data_out); end
  endtask

  task automatic test_write_first();
    do_write(6'd3, 16'h0000, 2'b11);
    wr_en = 1'b1; rd_en = 1'b1; mem_address = 6'd3; data_in = 16'hAAA1; be = 2'b11;
    cyc();
    idle();
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL wf_valid: got %b want 1", rd_valid); end
    total++; if (data_out !== 16'hAAA1) begin bad++; $display("FAIL wf_full: got %h want aaa1", data_out); end
    wr_en = 1'b1; rd_en = 1'b1; mem_address = 6'd3; data_in = 16'h5B5B; be = 2'b10;
    cyc();
    idle();
    total++; if (data_out !== 16'h5BA1) begin bad++; $display("FAIL wf_partial: got %h want 5ba1", data_out); end
    do_read(6'd3);
    total++; if (data_out !== 16'h5BA1) begin bad++; $display("FAIL wf_stored: got %h want 5ba1", data_out); end
    do_write(6'd63, 16'hBEEF, 2'b11);
    do_read(6'd63);
    total++; if (data_out !== 16'hBEEF) begin bad++; $display("FAIL addr63: got %h want beef", data_out); end
    do_read(6'd0);
    total++; if (data_out !== 16'h0C60) begin bad++; $display("FAIL addr0_alias: got %h want 0c60", data_out); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  addrs [3] = '{6'd0, 6'd1, 6'd63};
    logic [15:0] exps  [3] = '{16'h0C60, 16'h12E4, 16'hBEEF};
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_address = addrs[i];
      cyc();
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid %0d: got %b want 1", i, rd_valid); end
      total++; if (data_out !== exps[i]) begin bad++; $display("FAIL b2b_data %0d: got %h want %h", i, data_out, exps[i]); end
    end
    idle();
    cyc();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid: got %b want 0", rd_valid); end
    total++; if (data_out !== 16'hBEEF) begin bad++; $display("FAIL b2b_end_hold: got %h want beef", data_out); end
  endtask

  task automatic test_clear_err();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    repeat (10) cyc();
    do_write(6'd2, 16'h1111, 2'b11);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL clr_wr_err: got %b want 1", err); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL clr_ready: got %b want 0", ready); end
    cyc();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL clr_err_pulse: got %b want 0", err); end
    do_read(6'd4);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL clr_rd_err: got %b want 1", err); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL clr_rd_valid: got %b want 0", rd_valid); end
    wait_ready();
    do_read(6'd2);
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL clr_addr2: got %h want 0000", data_out); end
    do_read(6'd0);
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL clr_addr0: got %h want 0000", data_out); end
  endtask

  task automatic test_reset_mid_read();
    do_write(6'd5, 16'h1234, 2'b11);
    rd_en = 1'b1;
    mem_address = 6'd5;
    @(posedge clk);
    #2;
    total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL mid_pre_data: got %h want 1234", data_out); end
    rst = 1'b0;
    #1;
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL mid_data: got %h want 0000", data_out); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", rd_valid); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %b want 0", ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", err); end
    idle();
    @(negedge clk);
    cyc();
    rst = 1'b1;
    cyc();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_resweep: got %b want 0", ready); end
    wait_ready();
    do_read(6'd5);
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL mid_addr5: got %h want 0000", data_out); end
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_write_read();
    test_byte_enable();
    test_write_first();
    test_back_to_back();
    test_clear_err();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
